// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry circular buffer of {pc, inst}
// with valid/ready on both sides; a flush from EX empties it in one cycle.
module if_id_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        pc_i,
   input  logic [INST_W-1:0]        inst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic                     flush_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic [ADDR_W-1:0]        pc_o,
   output logic [INST_W-1:0]        inst_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              push;
   logic              pop;

   assign ready_o = (count != CW'(DEPTH));
   assign valid_o = (count != '0);
   assign pc_o    = pc_mem[rd_ptr];
   assign inst_o  = valid_o ? inst_mem[rd_ptr] : NOP_INST;
   assign count_o = count;

   assign push = valid_i & ready_o & ~flush_i;
   assign pop  = valid_o & ready_i & ~flush_i;

   // Flush keeps slot contents; valid_o=0 already masks them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= pc_i;
            inst_mem[wr_ptr] <= inst_i;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue with a queue-based
// reference model and a decoupled output monitor.
module tb_if_id_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic        valid_i;
   logic        ready_o;
   logic        flush_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic [2:0]  count_o;

   if_id_queue #(
      .ADDR_W  (32),
      .INST_W  (32),
      .DEPTH   (DEPTH),
      .NOP_INST(32'h0)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pc_i   (pc_i),
      .inst_i (inst_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .flush_i(flush_i),
      .ready_i(ready_i),
      .valid_o(valid_o),
      .pc_o   (pc_o),
      .inst_o (inst_o),
      .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int occ    = 0;
   int maxc   = 0;
   bit armed  = 0;
   logic [63:0] sb_q[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    name, act, exp, $time);
   endtask

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return (pc * 3) + 32'h13;
   endfunction

   // Reference model: a plain FIFO of accepted pairs plus an occupancy number.
   always @(posedge clk) begin
      if (!rst) begin
         armed = 1;
         occ   = 0;
         sb_q.delete();
      end else if (flush_i) begin
         occ = 0;
         sb_q.delete();
      end else begin
         bit pu;
         bit po;
         pu = valid_i && (occ < DEPTH);
         po = ready_i && (occ > 0);
         if (pu) sb_q.push_back({pc_i, inst_i});
         occ = occ + int'(pu) - int'(po);
      end
   end

   // Monitor: compare the head and status every cycle, retire on handshake.
   always @(negedge clk) begin
      if (armed) begin
         if (int'(count_o) > maxc) maxc = int'(count_o);
         chk("count", 64'(count_o), 64'(occ));
         chk("valid", 64'(valid_o), 64'(occ != 0));
         chk("ready", 64'(ready_o), 64'(occ != DEPTH));
         chk("sb_size", 64'(sb_q.size()), 64'(occ));
         if (occ != 0) begin
            if (sb_q.size() == 0) begin
               chk("sb_empty", 64'(1), 64'(0));
            end else begin
               chk("head_pc", 64'(pc_o), 64'(sb_q[0][63:32]));
               chk("head_inst", 64'(inst_o), 64'(sb_q[0][31:0]));
               if (ready_i && rst && !flush_i) void'(sb_q.pop_front());
            end
         end else begin
            chk("nop_inst", 64'(inst_o), 64'(0));
         end
      end
   end

   task automatic drive(input logic r, input logic v, input logic f,
                        input logic rd, input logic [31:0] pc);
      rst     = r;
      valid_i = v;
      flush_i = f;
      ready_i = rd;
      pc_i    = pc;
      inst_i  = mk_inst(pc);
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst     = 1'b0;
      valid_i = 1'b1;
      flush_i = 1'b0;
      ready_i = 1'b0;
      pc_i    = 32'h40;
      inst_i  = mk_inst(32'h40);
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", 64'(valid_o), 64'(0));
      chk("rst_inst", 64'(inst_o), 64'(0));
      chk("rst_pc", 64'(pc_o), 64'(0));
      chk("rst_count", 64'(count_o), 64'(0));
      chk("rst_ready", 64'(ready_o), 64'(1));

      // fill to full with ID stalled, then drain in order
      for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, 32'h100 + 32'(4 * k));
      chk("full_count", 64'(count_o), 64'(4));
      chk("full_ready", 64'(ready_o), 64'(0));
      drive(1, 1, 0, 0, 32'h110);
      chk("full_ignore", 64'(count_o), 64'(4));
      for (int k = 0; k < 4; k++) begin
         chk("drain_pc", 64'(pc_o), 64'(32'h100 + 32'(4 * k)));
         drive(1, 0, 0, 1, 32'h0);
      end
      chk("drain_empty", 64'(valid_o), 64'(0));

      // simultaneous push and pop at count 2
      drive(1, 1, 0, 0, 32'h300);
      drive(1, 1, 0, 0, 32'h304);
      chk("pp_count0", 64'(count_o), 64'(2));
      drive(1, 1, 0, 1, 32'h308);
      chk("pp_count1", 64'(count_o), 64'(2));
      chk("pp_head", 64'(pc_o), 64'(32'h304));
      drive(1, 0, 0, 1, 32'h0);
      chk("pp_tail", 64'(pc_o), 64'(32'h308));
      drive(1, 0, 0, 1, 32'h0);

      // flush drops queue and the concurrent push
      for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 32'h400 + 32'(4 * k));
      chk("fl_count0", 64'(count_o), 64'(3));
      drive(1, 1, 1, 0, 32'h40C);
      chk("fl_count", 64'(count_o), 64'(0));
      chk("fl_valid", 64'(valid_o), 64'(0));
      chk("fl_inst", 64'(inst_o), 64'(0));
      drive(1, 1, 0, 0, 32'h200);
      chk("fl_push_v", 64'(valid_o), 64'(1));
      chk("fl_push_pc", 64'(pc_o), 64'(32'h200));
      drive(1, 0, 0, 1, 32'h0);

      // streaming across pointer wrap
      maxc = 0;
      for (int k = 0; k < 10; k++) drive(1, 1, 0, 1, 32'h500 + 32'(4 * k));
      drive(1, 0, 0, 1, 32'h0);
      chk("stream_max", 64'(maxc <= 1), 64'(1));
      chk("stream_done", 64'(count_o), 64'(0));

      // reset mid-operation
      for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 32'h600 + 32'(4 * k));
      chk("mr_count0", 64'(count_o), 64'(3));
      drive(0, 1, 0, 1, 32'h60C);
      chk("mr_valid", 64'(valid_o), 64'(0));
      chk("mr_count", 64'(count_o), 64'(0));
      chk("mr_pc", 64'(pc_o), 64'(0));
      chk("mr_inst", 64'(inst_o), 64'(0));
      chk("mr_ready", 64'(ready_o), 64'(1));
      drive(1, 0, 0, 1, 32'h0);
      chk("mr_stay", 64'(valid_o), 64'(0));
      drive(1, 1, 0, 0, 32'h700);
      chk("mr_new_pc", 64'(pc_o), 64'(32'h700));

      // random traffic
      for (int k = 0; k < 600; k++) begin
         drive(($urandom % 60) != 0, ($urandom % 4) != 0,
               ($urandom % 16) == 0, ($urandom % 3) != 0,
               $urandom & 32'hFFFF_FFFC);
      end
      for (int k = 0; k < 6; k++) drive(1, 0, 0, 1, 32'h0);
      chk("final_empty", 64'(count_o), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
